demux_2lane: RTL and testbench

DEMUX_2LANE -- requirements
Module: demux_2lane

---
 rtl/demux_2lane.sv | 105 ++++++++++
 tb/tb_demux_2lane.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/demux_2lane.sv
// Two-lane byte demultiplexer: an alternating lane selector feeds two 4-entry FWFT FIFOs.
// Define DEMUX_ERR_CNT_EN to add the saturating underflow counter on err_cnt.
module demux_2lane (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_in,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic       valid_out_0,
  output logic       valid_out_1,
  input  logic       pop_0,
  input  logic       pop_1,
  output logic       full_0,
  output logic       full_1
`ifdef DEMUX_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  logic            sel_q, sel_d;
  logic [1:0][1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0][1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0][2:0] cnt_q, cnt_d;
  logic [7:0]      mem_q [2][4];

  logic [1:0] full, valid, pop_req, push_l, pop_l;
  logic       push;

  assign pop_req = {pop_1, pop_0};

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      full[l]  = (cnt_q[l] == 3'd4);
      valid[l] = (cnt_q[l] != 3'd0);
    end
    ready_in = sel_q ? !full[1] : !full[0];
    push     = valid_in && ready_in;
    push_l   = {push && sel_q, push && !sel_q};
    pop_l    = pop_req & valid;
  end

  // A push to a full lane is already blocked by ready_in, so a same-cycle pop never collides.
  always_comb begin
    sel_d    = push ? !sel_q : sel_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    for (int l = 0; l < 2; l++) begin
      if (push_l[l]) wr_ptr_d[l] = wr_ptr_q[l] + 2'd1;
      if (pop_l[l])  rd_ptr_d[l] = rd_ptr_q[l] + 2'd1;
      cnt_d[l] = cnt_q[l] + {2'b00, push_l[l]} - {2'b00, pop_l[l]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      sel_q    <= sel_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; valid_out gates its visibility.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (push_l[l]) mem_q[l][wr_ptr_q[l]] <= data_in;
    end
  end

  assign data_out_0  = mem_q[0][rd_ptr_q[0]];
  assign data_out_1  = mem_q[1][rd_ptr_q[1]];
  assign valid_out_0 = valid[0];
  assign valid_out_1 = valid[1];
  assign full_0      = full[0];
  assign full_1      = full[1];

`ifdef DEMUX_ERR_CNT_EN
  logic [1:0] underflow;
  logic [7:0] err_q, err_d;
  logic [8:0] err_sum;

  always_comb begin
    underflow = pop_req & ~valid;
    err_sum   = {1'b0, err_q} + {8'd0, underflow[0]} + {8'd0, underflow[1]};
    err_d     = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 8'd0;
    else        err_q <= err_d;
  end

  assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_demux_2lane.sv
// Directed self-checking bench for demux_2lane; build with DEMUX_ERR_CNT_EN to cover err_cnt.
module tb_demux_2lane;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_in;
  logic [7:0] data_out_0, data_out_1;
  logic       valid_out_0, valid_out_1;
  logic       pop_0, pop_1;
  logic       full_0, full_1;
`ifdef DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  demux_2lane dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .data_out_0 (data_out_0),
    .data_out_1 (data_out_1),
    .valid_out_0(valid_out_0),
    .valid_out_1(valid_out_1),
    .pop_0      (pop_0),
    .pop_1      (pop_1),
    .full_0     (full_0),
    .full_1     (full_1)
`ifdef DEMUX_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp0 [4];
  logic [7:0] exp1 [4];

  initial begin
    reset    = 1'b0;
    data_in  = 8'h00;
    valid_in = 1'b0;
    pop_0    = 1'b0;
    pop_1    = 1'b0;
    #3;
    chk("rst_valid0", 32'(valid_out_0), 32'd0);
    chk("rst_valid1", 32'(valid_out_1), 32'd0);
    chk("rst_full",   32'({full_1, full_0}), 32'd0);
    chk("rst_ready",  32'(ready_in), 32'd1);
`ifdef DEMUX_ERR_CNT_EN
    chk("rst_err", 32'(err_cnt), 32'd0);
`endif
    #3 reset = 1'b1;
    step();

    // Interleaved push: 11,FF,12,FE
    valid_in = 1'b1; data_in = 8'h11; step();
    chk("lat_valid0", 32'(valid_out_0), 32'd1);
    chk("lat_data0",  32'(data_out_0), 32'h11);
    chk("lat_valid1", 32'(valid_out_1), 32'd0);
    data_in = 8'hFF; step();
    data_in = 8'h12; step();
    data_in = 8'hFE; step();
    valid_in = 1'b0;
    chk("il_valid", 32'({valid_out_1, valid_out_0}), 32'h3);
    chk("il_data0", 32'(data_out_0), 32'h11);
    chk("il_data1", 32'(data_out_1), 32'hFF);
    pop_0 = 1'b1; pop_1 = 1'b1; step();
    chk("il_pop_data0", 32'(data_out_0), 32'h12);
    chk("il_pop_data1", 32'(data_out_1), 32'hFE);
    step();
    pop_0 = 1'b0; pop_1 = 1'b0;
    chk("il_empty", 32'({valid_out_1, valid_out_0}), 32'h0);

    // Fill both lanes, then offer a 9th word
    valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 8'h20 + 8'(i);
      step();
    end
    chk("fill_full",  32'({full_1, full_0}), 32'h3);
    chk("fill_ready", 32'(ready_in), 32'd0);
    data_in = 8'h99; step();
    chk("ninth_full",  32'({full_1, full_0}), 32'h3);
    chk("ninth_ready", 32'(ready_in), 32'd0);
    chk("ninth_head0", 32'(data_out_0), 32'h20);

    // Full lane: push refused while pop executes, accepted next cycle
    pop_0 = 1'b1;
    chk("fp_ready_pre", 32'(ready_in), 32'd0);
    step();
    pop_0 = 1'b0;
    chk("fp_full0",  32'(full_0), 32'd0);
    chk("fp_head0",  32'(data_out_0), 32'h22);
    chk("fp_ready",  32'(ready_in), 32'd1);
    step();
    valid_in = 1'b0;
    chk("fp_full0_again", 32'(full_0), 32'd1);
    chk("fp_ready_sel1",  32'(ready_in), 32'd0);

    exp0 = '{8'h22, 8'h24, 8'h26, 8'h99};
    exp1 = '{8'h21, 8'h23, 8'h25, 8'h27};
    pop_0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain0_%0d", k), 32'(data_out_0), 32'(exp0[k]));
      step();
    end
    pop_0 = 1'b0;
    chk("drain0_empty", 32'(valid_out_0), 32'd0);
    pop_1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain1_%0d", k), 32'(data_out_1), 32'(exp1[k]));
      step();
    end
    pop_1 = 1'b0;
    chk("drain1_empty", 32'(valid_out_1), 32'd0);

    // Mid-stream reset with 3 words buffered (sel is 1 here)
    valid_in = 1'b1;
    data_in = 8'hA0; step();
    data_in = 8'hA1; step();
    data_in = 8'hA2; step();
    valid_in = 1'b0;
    chk("pre_rst_valid", 32'({valid_out_1, valid_out_0}), 32'h3);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'({valid_out_1, valid_out_0}), 32'h0);
    chk("async_rst_ready", 32'(ready_in), 32'd1);
    #2 reset = 1'b1;

    // Push/pop on the same lane each cycle; lane 0 pointers wrap
    for (int i = 0; i < 13; i++) begin
      valid_in = 1'b1;
      data_in  = 8'h13 + 8'(i);
      pop_0    = (i >= 2) && (i % 2 == 0);
      pop_1    = (i >= 3) && (i % 2 == 1);
      if (pop_0) chk($sformatf("pp_out0_%0d", i), 32'(data_out_0), 32'h13 + 32'(i) - 32'd2);
      if (pop_1) chk($sformatf("pp_out1_%0d", i), 32'(data_out_1), 32'h13 + 32'(i) - 32'd2);
      step();
      if (i == 0) begin
        chk("post_rst_lane0", 32'({valid_out_0, data_out_0}), 32'h113);
        chk("post_rst_lane1", 32'(valid_out_1), 32'd0);
      end
    end
    valid_in = 1'b0; pop_0 = 1'b0; pop_1 = 1'b0;
    chk("pp_tail0", 32'({full_0, valid_out_0, data_out_0}), 32'h11F);
    chk("pp_tail1", 32'({full_1, valid_out_1, data_out_1}), 32'h11E);
    pop_0 = 1'b1; pop_1 = 1'b1; step();
    chk("pp_empty", 32'({valid_out_1, valid_out_0}), 32'h0);

    // Underflow: single lane, then both lanes for a long stretch
    pop_1 = 1'b0; step();
`ifdef DEMUX_ERR_CNT_EN
    chk("uf_single", 32'(err_cnt), 32'd1);
`endif
    pop_1 = 1'b1; step();
`ifdef DEMUX_ERR_CNT_EN
    chk("uf_double", 32'(err_cnt), 32'd3);
`endif
    repeat (130) step();
    pop_0 = 1'b0; pop_1 = 1'b0;
    chk("uf_still_empty", 32'({valid_out_1, valid_out_0}), 32'h0);
    chk("uf_ready", 32'(ready_in), 32'd1);
`ifdef DEMUX_ERR_CNT_EN
    chk("uf_saturate", 32'(err_cnt), 32'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
